// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_pkg
//  Brief    : Shared types and helpers for the cache line refill controller.
//  Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WB   = 3'd1,
        ST_RD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_FILL = 3'd4
    } state_t;

    localparam int c_line_addr_max = 32;

    function automatic bit addr_width_ok(input int addr_bit, input int tag_bit,
                                         input int index_bit);
        return (addr_bit == tag_bit + index_bit);
    endfunction

    // Line address is {tag,index}; callers zero-extend and truncate to their widths.
    function automatic logic [c_line_addr_max-1:0] line_addr(
        input logic [c_line_addr_max-1:0] tag,
        input logic [c_line_addr_max-1:0] index,
        input int                         index_bit);
        return (tag << index_bit) | index;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Brief    : Event counter that sticks at all-ones instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_BIT = 16
) (
    input  logic               clk_sys_i,
    input  logic               rst_sys_n_i,
    input  logic               inc_i,
    output logic [CNT_BIT-1:0] cnt_o
);

    logic [CNT_BIT-1:0] r_cnt;

    always_ff @(posedge clk_sys_i or negedge rst_sys_n_i) begin
        if (!rst_sys_n_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {CNT_BIT{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: rtl/cache_line_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cache_line_refill_ctrl
//  Brief    : Miss engine: dirty write-back, line read with configurable SRAM
//             latency, line fill into the chosen way, and miss/WB statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_line_refill_ctrl
    import cache_pkg::*;
#(
    parameter int SETS_BIT      = 2,
    parameter int TAG_BIT       = 7,
    parameter int INDEX_BIT     = 2,
    parameter int SRAM_ADDR_BIT = 9,
    parameter int SRAM_DATA_BIT = 1024,
    parameter int SRAM_RD_LAT   = 1,
    parameter int CNT_BIT       = 16
) (
    input  logic                     clk_sys_i,
    input  logic                     rst_sys_n_i,
    input  logic                     miss_req_i,
    input  logic [TAG_BIT-1:0]       miss_tag_i,
    input  logic [INDEX_BIT-1:0]     miss_index_i,
    input  logic [SETS_BIT-1:0]      miss_way_i,
    input  logic                     victim_dirty_i,
    input  logic [TAG_BIT-1:0]       victim_tag_i,
    input  logic [SRAM_DATA_BIT-1:0] victim_line_i,
    output logic                     miss_ack_o,
    output logic                     busy_o,
    output logic                     fill_valid_o,
    output logic [SETS_BIT-1:0]      fill_way_o,
    output logic [INDEX_BIT-1:0]     fill_index_o,
    output logic [TAG_BIT-1:0]       fill_tag_o,
    output logic [SRAM_DATA_BIT-1:0] fill_line_o,
    output logic                     SRAM_ena_o,
    output logic                     SRAM_wea_o,
    output logic [SRAM_ADDR_BIT-1:0] SRAM_addr_o,
    output logic [SRAM_DATA_BIT-1:0] SRAM_data_o,
    input  logic [SRAM_DATA_BIT-1:0] SRAM_data_i,
    output logic [CNT_BIT-1:0]       miss_cnt_o,
    output logic [CNT_BIT-1:0]       wb_cnt_o
);

    if (!addr_width_ok(SRAM_ADDR_BIT, TAG_BIT, INDEX_BIT)) begin : g_addr_width_err
        $error("SRAM_ADDR_BIT must equal TAG_BIT+INDEX_BIT");
    end
    if ((SRAM_RD_LAT < 1) || (SRAM_RD_LAT > 8)) begin : g_rd_lat_err
        $error("SRAM_RD_LAT must be within 1..8");
    end

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       w_take;
    logic [TAG_BIT-1:0]         r_tag;
    logic [INDEX_BIT-1:0]       r_index;
    logic [SETS_BIT-1:0]        r_way;
    logic                       r_dirty;
    logic [3:0]                 r_lat;
    logic [SRAM_DATA_BIT-1:0]   r_fill_line;
    logic                       r_sram_ena;
    logic                       r_sram_wea;
    logic [SRAM_ADDR_BIT-1:0]   r_sram_addr;
    logic [SRAM_DATA_BIT-1:0]   r_sram_data;
    logic [TAG_BIT-1:0]         w_addr_tag;
    logic [INDEX_BIT-1:0]       w_addr_index;
    logic [c_line_addr_max-1:0] w_tag_ext;
    logic [c_line_addr_max-1:0] w_index_ext;
    logic [c_line_addr_max-1:0] w_addr_full;
    logic [c_line_addr_max-SRAM_ADDR_BIT-1:0] w_addr_hi_unused;
    logic [SRAM_ADDR_BIT-1:0]   w_sram_addr_nxt;

    assign w_take = (r_state == ST_IDLE) && miss_req_i;

    always_ff @(posedge clk_sys_i or negedge rst_sys_n_i) begin
        if (!rst_sys_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (miss_req_i) w_state_nxt = victim_dirty_i ? ST_WB : ST_RD;
            ST_WB:   w_state_nxt = ST_RD;
            ST_RD:   w_state_nxt = ST_WAIT;
            ST_WAIT: if (r_lat == 4'd1) w_state_nxt = ST_FILL;
            ST_FILL: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // SRAM outputs are registered, so the address for the next state is
    // formed now: victim line on a dirty accept, requested line otherwise.
    always_comb begin
        w_addr_tag   = r_tag;
        w_addr_index = r_index;
        if (w_take) begin
            w_addr_index = miss_index_i;
            w_addr_tag   = victim_dirty_i ? victim_tag_i : miss_tag_i;
        end
    end

    assign w_tag_ext   = c_line_addr_max'(w_addr_tag);
    assign w_index_ext = c_line_addr_max'(w_addr_index);
    assign w_addr_full = line_addr(w_tag_ext, w_index_ext, INDEX_BIT);
    assign {w_addr_hi_unused, w_sram_addr_nxt} = w_addr_full;

    always_ff @(posedge clk_sys_i or negedge rst_sys_n_i) begin
        if (!rst_sys_n_i) begin
            r_tag       <= '0;
            r_index     <= '0;
            r_way       <= '0;
            r_dirty     <= 1'b0;
            r_lat       <= '0;
            r_fill_line <= '0;
            r_sram_ena  <= 1'b0;
            r_sram_wea  <= 1'b0;
            r_sram_addr <= '0;
            r_sram_data <= '0;
        end else begin
            if (w_take) begin
                r_tag   <= miss_tag_i;
                r_index <= miss_index_i;
                r_way   <= miss_way_i;
                r_dirty <= victim_dirty_i;
                if (victim_dirty_i) begin
                    r_sram_data <= victim_line_i;
                end
            end
            r_sram_ena <= (w_state_nxt == ST_WB) || (w_state_nxt == ST_RD);
            r_sram_wea <= (w_state_nxt == ST_WB);
            if ((w_state_nxt == ST_WB) || (w_state_nxt == ST_RD)) begin
                r_sram_addr <= w_sram_addr_nxt;
            end
            if (r_state == ST_RD) begin
                r_lat <= 4'(SRAM_RD_LAT);
            end else if (r_state == ST_WAIT) begin
                r_lat <= r_lat - 4'd1;
            end
            if ((r_state == ST_WAIT) && (r_lat == 4'd1)) begin
                r_fill_line <= SRAM_data_i;
            end
        end
    end

    sat_counter #(.CNT_BIT(CNT_BIT)) u_miss_cnt (
        .clk_sys_i   (clk_sys_i),
        .rst_sys_n_i (rst_sys_n_i),
        .inc_i       (w_take),
        .cnt_o       (miss_cnt_o)
    );

    sat_counter #(.CNT_BIT(CNT_BIT)) u_wb_cnt (
        .clk_sys_i   (clk_sys_i),
        .rst_sys_n_i (rst_sys_n_i),
        .inc_i       ((r_state == ST_WB) && r_dirty),
        .cnt_o       (wb_cnt_o)
    );

    assign miss_ack_o   = (r_state == ST_FILL);
    assign fill_valid_o = (r_state == ST_FILL);
    assign busy_o       = (r_state != ST_IDLE);
    assign fill_way_o   = r_way;
    assign fill_index_o = r_index;
    assign fill_tag_o   = r_tag;
    assign fill_line_o  = r_fill_line;
    assign SRAM_ena_o   = r_sram_ena;
    assign SRAM_wea_o   = r_sram_wea;
    assign SRAM_addr_o  = r_sram_addr;
    assign SRAM_data_o  = r_sram_data;

endmodule
`default_nettype wire

// File: tb/tb_cache_line_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_line_refill_ctrl
//  Brief    : Directed bench for the refill controller: default, latency-4 and
//             2-bit-counter builds, each with its own request line.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_line_refill_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_clr = 1'b1;
    always #5 clk = ~clk;

    logic          req0 = 1'b0, req1 = 1'b0, req2 = 1'b0;
    logic [6:0]    miss_tag = '0, victim_tag = '0;
    logic [1:0]    miss_index = '0, miss_way = '0;
    logic          victim_dirty = 1'b0;
    logic [1023:0] victim_line = '0;

    logic          ack0, ack1, ack2, busy0, busy1, busy2, fv0, fv1, fv2;
    logic [1:0]    fway0, fway1, fway2, fidx0, fidx1, fidx2;
    logic [6:0]    ftag0, ftag1, ftag2;
    logic [1023:0] fline0, fline1, fline2, wdat0, wdat1, wdat2;
    logic          ena0, ena1, ena2, wea0, wea1, wea2;
    logic [8:0]    addr0, addr1, addr2;
    logic [1023:0] rdata0;
    logic [15:0]   mcnt0, mcnt1, wcnt0, wcnt1;
    logic [1:0]    mcnt2, wcnt2;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] KNOWN = 64'h0123456789abcdef;

    function automatic logic [1023:0] pattern(input logic [8:0] a);
        logic [1023:0] l;
        l = '0;
        if (a == 9'h040) l[176 +: 64] = KNOWN;
        else             l[176 +: 64] = {55'h0, a} | 64'hA5A5_0000_0000_0000;
        l[8:0] = a;
        return l;
    endfunction

    // Default-build SRAM: latency 1, unwritten lines return pattern(addr)
    logic [1023:0] mem0 [512];
    logic [511:0]  vld0;
    always @(posedge clk) begin
        if (mem_clr) begin
            vld0 <= '0;
        end else if (ena0) begin
            if (wea0) begin
                mem0[addr0] <= wdat0;
                vld0[addr0] <= 1'b1;
            end else begin
                rdata0 <= vld0[addr0] ? mem0[addr0] : pattern(addr0);
            end
        end
    end

    // Latency-4 SRAM: read-only pattern through a 4-stage pipe
    logic [1023:0] p4 [4];
    always @(posedge clk) begin
        if (ena1 && !wea1) p4[0] <= pattern(addr1);
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end

    cache_line_refill_ctrl dut (
        .clk_sys_i(clk), .rst_sys_n_i(rst_n), .miss_req_i(req0),
        .miss_tag_i(miss_tag), .miss_index_i(miss_index), .miss_way_i(miss_way),
        .victim_dirty_i(victim_dirty), .victim_tag_i(victim_tag), .victim_line_i(victim_line),
        .miss_ack_o(ack0), .busy_o(busy0), .fill_valid_o(fv0), .fill_way_o(fway0),
        .fill_index_o(fidx0), .fill_tag_o(ftag0), .fill_line_o(fline0),
        .SRAM_ena_o(ena0), .SRAM_wea_o(wea0), .SRAM_addr_o(addr0), .SRAM_data_o(wdat0),
        .SRAM_data_i(rdata0), .miss_cnt_o(mcnt0), .wb_cnt_o(wcnt0));

    cache_line_refill_ctrl #(.SRAM_RD_LAT(4)) dut_lat4 (
        .clk_sys_i(clk), .rst_sys_n_i(rst_n), .miss_req_i(req1),
        .miss_tag_i(miss_tag), .miss_index_i(miss_index), .miss_way_i(miss_way),
        .victim_dirty_i(victim_dirty), .victim_tag_i(victim_tag), .victim_line_i(victim_line),
        .miss_ack_o(ack1), .busy_o(busy1), .fill_valid_o(fv1), .fill_way_o(fway1),
        .fill_index_o(fidx1), .fill_tag_o(ftag1), .fill_line_o(fline1),
        .SRAM_ena_o(ena1), .SRAM_wea_o(wea1), .SRAM_addr_o(addr1), .SRAM_data_o(wdat1),
        .SRAM_data_i(p4[3]), .miss_cnt_o(mcnt1), .wb_cnt_o(wcnt1));

    cache_line_refill_ctrl #(.CNT_BIT(2)) dut_cnt2 (
        .clk_sys_i(clk), .rst_sys_n_i(rst_n), .miss_req_i(req2),
        .miss_tag_i(miss_tag), .miss_index_i(miss_index), .miss_way_i(miss_way),
        .victim_dirty_i(victim_dirty), .victim_tag_i(victim_tag), .victim_line_i(victim_line),
        .miss_ack_o(ack2), .busy_o(busy2), .fill_valid_o(fv2), .fill_way_o(fway2),
        .fill_index_o(fidx2), .fill_tag_o(ftag2), .fill_line_o(fline2),
        .SRAM_ena_o(ena2), .SRAM_wea_o(wea2), .SRAM_addr_o(addr2), .SRAM_data_o(wdat2),
        .SRAM_data_i('0), .miss_cnt_o(mcnt2), .wb_cnt_o(wcnt2));

    // Observations recorded by issue_miss
    int            rec_ack_cyc, rec_acks, rec_acc_n;
    int            rec_acc_cyc [4];
    logic [8:0]    rec_acc_addr [4];
    logic          rec_acc_wea [4];
    logic [1023:0] rec_acc_data [4];
    logic          rec_fv;
    logic [1:0]    rec_fway, rec_fidx;
    logic [6:0]    rec_ftag;
    logic [1023:0] rec_fline;

    task automatic set_req(input int sel, input logic v);
        case (sel)
            0:       req0 = v;
            1:       req1 = v;
            default: req2 = v;
        endcase
    endtask

    task automatic issue_miss(input int sel, input logic [6:0] tag, input logic [1:0] idx,
                              input logic [1:0] way, input logic dirty, input logic [6:0] vtag,
                              input logic [1023:0] vline, input int drop_at);
        int cyc;
        bit done;
        logic o_ack, o_ena, o_wea, o_fv;
        logic [8:0] o_addr;
        logic [1023:0] o_wdat, o_fline;
        logic [1:0] o_fway, o_fidx;
        logic [6:0] o_ftag;
        rec_ack_cyc = -1; rec_acks = 0; rec_acc_n = 0;
        @(negedge clk);
        miss_tag = tag; miss_index = idx; miss_way = way;
        victim_dirty = dirty; victim_tag = vtag; victim_line = vline;
        set_req(sel, 1'b1);
        cyc = 0; done = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == drop_at) set_req(sel, 1'b0);
            case (sel)
                0: begin o_ack = ack0; o_ena = ena0; o_wea = wea0; o_addr = addr0; o_wdat = wdat0;
                         o_fv = fv0; o_fway = fway0; o_fidx = fidx0; o_ftag = ftag0; o_fline = fline0; end
                1: begin o_ack = ack1; o_ena = ena1; o_wea = wea1; o_addr = addr1; o_wdat = wdat1;
                         o_fv = fv1; o_fway = fway1; o_fidx = fidx1; o_ftag = ftag1; o_fline = fline1; end
                default: begin o_ack = ack2; o_ena = ena2; o_wea = wea2; o_addr = addr2; o_wdat = wdat2;
                         o_fv = fv2; o_fway = fway2; o_fidx = fidx2; o_ftag = ftag2; o_fline = fline2; end
            endcase
            if (o_ena && rec_acc_n < 4) begin
                rec_acc_cyc[rec_acc_n]  = cyc;
                rec_acc_addr[rec_acc_n] = o_addr;
                rec_acc_wea[rec_acc_n]  = o_wea;
                rec_acc_data[rec_acc_n] = o_wdat;
                rec_acc_n++;
            end
            if (o_ack) begin
                rec_acks++;
                if (rec_ack_cyc < 0) begin
                    rec_ack_cyc = cyc;
                    rec_fv = o_fv; rec_fway = o_fway; rec_fidx = o_fidx;
                    rec_ftag = o_ftag; rec_fline = o_fline;
                    set_req(sel, 1'b0);
                end
            end
            if (rec_ack_cyc >= 0 && cyc >= rec_ack_cyc + 2) done = 1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL ack_timeout inst=%0d: no ack within %0d cycles", sel, cyc);
            set_req(sel, 1'b0);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mem_clr = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack0, busy0, fv0, ena0, wea0} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {ack0, busy0, fv0, ena0, wea0});
        end
        checks++;
        if ({fway0, fidx0, ftag0, addr0} !== 20'h0 || fline0 !== '0 || wdat0 !== '0) begin
            errors++; $display("FAIL reset_data: way=%h idx=%h tag=%h addr=%h", fway0, fidx0, ftag0, addr0);
        end
        checks++;
        if (mcnt0 !== 16'd0 || wcnt0 !== 16'd0 || mcnt2 !== 2'd0) begin
            errors++; $display("FAIL reset_cnt: miss=%0d wb=%0d want 0 0", mcnt0, wcnt0);
        end
        rst_n = 1'b1; mem_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin
            errors++; $display("FAIL reset_release_busy: got %b want 0", busy0);
        end
    endtask

    task automatic test_clean_miss;
        issue_miss(0, 7'h10, 2'd0, 2'd2, 1'b0, 7'h00, '0, -1);
        checks++;
        if (rec_acc_n !== 1 || rec_acc_cyc[0] !== 1 || rec_acc_addr[0] !== 9'h040 || rec_acc_wea[0] !== 1'b0) begin
            errors++; $display("FAIL clean_rd: n=%0d cyc=%0d addr=%h wea=%b want 1 1 040 0",
                               rec_acc_n, rec_acc_cyc[0], rec_acc_addr[0], rec_acc_wea[0]);
        end
        checks++;
        if (rec_ack_cyc !== 3 || rec_acks !== 1) begin
            errors++; $display("FAIL clean_ack: cyc=%0d acks=%0d want 3 1", rec_ack_cyc, rec_acks);
        end
        checks++;
        if (rec_fline[176 +: 64] !== KNOWN || rec_fway !== 2'd2 || rec_ftag !== 7'h10 ||
            rec_fidx !== 2'd0 || rec_fv !== 1'b1) begin
            errors++; $display("FAIL clean_fill: data=%h way=%0d tag=%h fv=%b want %h 2 10 1",
                               rec_fline[176 +: 64], rec_fway, rec_ftag, rec_fv, KNOWN);
        end
        checks++;
        if (mcnt0 !== 16'd1 || wcnt0 !== 16'd0) begin
            errors++; $display("FAIL clean_cnt: miss=%0d wb=%0d want 1 0", mcnt0, wcnt0);
        end
    endtask

    task automatic test_dirty_miss;
        logic [1023:0] vline_a;
        vline_a = {16{64'hFEED_FACE_CAFE_0001}};
        issue_miss(0, 7'h10, 2'd0, 2'd3, 1'b1, 7'h11, vline_a, -1);
        checks++;
        if (rec_acc_n !== 2 || rec_acc_cyc[0] !== 1 || rec_acc_addr[0] !== 9'h044 ||
            rec_acc_wea[0] !== 1'b1 || rec_acc_data[0] !== vline_a) begin
            errors++; $display("FAIL dirty_wb: n=%0d cyc=%0d addr=%h wea=%b want 2 1 044 1",
                               rec_acc_n, rec_acc_cyc[0], rec_acc_addr[0], rec_acc_wea[0]);
        end
        checks++;
        if (rec_acc_cyc[1] !== 2 || rec_acc_addr[1] !== 9'h040 || rec_acc_wea[1] !== 1'b0) begin
            errors++; $display("FAIL dirty_rd: cyc=%0d addr=%h wea=%b want 2 040 0",
                               rec_acc_cyc[1], rec_acc_addr[1], rec_acc_wea[1]);
        end
        checks++;
        if (rec_ack_cyc !== 4 || wcnt0 !== 16'd1 || mcnt0 !== 16'd2) begin
            errors++; $display("FAIL dirty_ack: cyc=%0d wb=%0d miss=%0d want 4 1 2", rec_ack_cyc, wcnt0, mcnt0);
        end
        issue_miss(0, 7'h11, 2'd0, 2'd1, 1'b0, 7'h00, '0, -1);
        checks++;
        if (rec_acc_addr[0] !== 9'h044 || rec_fline !== vline_a || mcnt0 !== 16'd3) begin
            errors++; $display("FAIL readback: addr=%h data=%h miss=%0d want 044 %h 3",
                               rec_acc_addr[0], rec_fline[63:0], mcnt0, vline_a[63:0]);
        end
    endtask

    task automatic test_drop_mid;
        issue_miss(0, 7'h05, 2'd2, 2'd0, 1'b0, 7'h00, '0, 1);
        checks++;
        if (rec_ack_cyc !== 3 || rec_acks !== 1 || rec_fline[8:0] !== 9'h016 || mcnt0 !== 16'd4) begin
            errors++; $display("FAIL drop_mid: cyc=%0d acks=%0d line=%h miss=%0d want 3 1 016 4",
                               rec_ack_cyc, rec_acks, rec_fline[8:0], mcnt0);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, first;
        @(negedge clk);
        miss_tag = 7'h10; miss_index = 2'd0; miss_way = 2'd0; victim_dirty = 1'b0;
        req0 = 1'b1;
        cyc = 0; first = -1;
        while (first < 0 && cyc < 40) begin
            @(negedge clk); cyc++;
            if (ack0) first = cyc;
        end
        miss_tag = 7'h12;
        @(negedge clk); cyc++;
        checks++;
        if (first !== 3 || busy0 !== 1'b0 || mcnt0 !== 16'd5) begin
            errors++; $display("FAIL b2b_idle: ack=%0d busy=%b miss=%0d want 3 0 5", first, busy0, mcnt0);
        end
        @(negedge clk); cyc++;
        checks++;
        if (busy0 !== 1'b1 || ena0 !== 1'b1 || addr0 !== 9'h048 || mcnt0 !== 16'd6) begin
            errors++; $display("FAIL b2b_accept: busy=%b ena=%b addr=%h miss=%0d want 1 1 048 6",
                               busy0, ena0, addr0, mcnt0);
        end
        first = -1;
        while (first < 0 && cyc < 40) begin
            @(negedge clk); cyc++;
            if (ack0) first = cyc;
        end
        req0 = 1'b0;
        checks++;
        if (first !== 7 || ftag0 !== 7'h12) begin
            errors++; $display("FAIL b2b_second_ack: cyc=%0d tag=%h want 7 12", first, ftag0);
        end
    endtask

    task automatic test_reset_mid;
        int acks;
        @(negedge clk);
        miss_tag = 7'h10; miss_index = 2'd0; miss_way = 2'd1; victim_dirty = 1'b0;
        req0 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy0 !== 1'b1 || ena0 !== 1'b0) begin
            errors++; $display("FAIL wait_state: busy=%b ena=%b want 1 0", busy0, ena0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ack0, busy0, fv0, ena0} !== 4'b0 || mcnt0 !== 16'd0 || fline0 !== '0 || fway0 !== 2'd0) begin
            errors++; $display("FAIL reset_mid: ack=%b busy=%b ena=%b miss=%0d want 0 0 0 0",
                               ack0, busy0, ena0, mcnt0);
        end
        acks = 0;
        @(negedge clk); req0 = 1'b0;
        if (ack0) acks++;
        @(negedge clk); rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (ack0) acks++;
        end
        checks++;
        if (acks !== 0) begin
            errors++; $display("FAIL reset_no_ack: got %0d acks want 0", acks);
        end
        issue_miss(0, 7'h10, 2'd0, 2'd1, 1'b0, 7'h00, '0, -1);
        checks++;
        if (rec_ack_cyc !== 3 || mcnt0 !== 16'd1 || rec_fline[176 +: 64] !== KNOWN) begin
            errors++; $display("FAIL after_reset: cyc=%0d miss=%0d want 3 1", rec_ack_cyc, mcnt0);
        end
    endtask

    task automatic test_lat4;
        issue_miss(1, 7'h10, 2'd0, 2'd2, 1'b0, 7'h00, '0, -1);
        checks++;
        if (rec_ack_cyc !== 6 || rec_acks !== 1) begin
            errors++; $display("FAIL lat4_ack: cyc=%0d acks=%0d want 6 1", rec_ack_cyc, rec_acks);
        end
        checks++;
        if (rec_acc_n !== 1 || rec_acc_cyc[0] !== 1 || rec_acc_addr[0] !== 9'h040) begin
            errors++; $display("FAIL lat4_ena: n=%0d cyc=%0d addr=%h want 1 1 040",
                               rec_acc_n, rec_acc_cyc[0], rec_acc_addr[0]);
        end
        checks++;
        if (rec_fline[176 +: 64] !== KNOWN || mcnt1 !== 16'd1 || wcnt1 !== 16'd0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL lat4_fill: data=%h miss=%0d wb=%0d busy=%b want %h 1 0 0",
                               rec_fline[176 +: 64], mcnt1, wcnt1, busy1, KNOWN);
        end
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 5; i++) begin
            issue_miss(2, 7'(i), 2'd1, 2'd0, 1'b0, 7'h00, '0, -1);
            if (i == 1) begin
                checks++;
                if (mcnt2 !== 2'd2) begin
                    errors++; $display("FAIL sat_mid: miss=%0d want 2", mcnt2);
                end
            end
        end
        checks++;
        if (mcnt2 !== 2'd3 || wcnt2 !== 2'd0 || busy2 !== 1'b0) begin
            errors++; $display("FAIL sat_final: miss=%0d wb=%0d busy=%b want 3 0 0", mcnt2, wcnt2, busy2);
        end
    endtask

    initial begin
        test_reset;
        test_clean_miss;
        test_dirty_miss;
        test_drop_mid;
        test_back_to_back;
        test_reset_mid;
        test_lat4;
        test_saturate;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_line_refill_ctrl.md
Name: cache_line_refill_ctrl

Overview:
- Miss-handling engine between a set-associative cache array and the wide line-organised SRAM.
- On a miss it writes back the dirty victim line, reads the requested line, and waits a parametrised SRAM read latency.
- It then presents the line for fill into the selected way and acknowledges the cache.
- Generalises the single-cycle cache/SRAM pairing to configurable geometry, read latency, write-back and miss/write-back statistics.

Parameters:
SETS_BIT, 2, log2 of number of ways
TAG_BIT, 7, tag width
INDEX_BIT, 2, set index width
SRAM_ADDR_BIT, 9, SRAM line address width; must equal TAG_BIT+INDEX_BIT
SRAM_DATA_BIT, 1024, line width (2^OFFSET_BIT bits)
SRAM_RD_LAT, 1, SRAM read latency in cycles, legal range 1..8
CNT_BIT, 16, statistics counter width

Ports:
clk_sys_i  in  1  system clock
rst_sys_n_i  in  1  asynchronous active-low reset
miss_req_i  in  1  miss request level; held until miss_ack_o
miss_tag_i  in  TAG_BIT  requested tag
miss_index_i  in  INDEX_BIT  requested set
miss_way_i  in  SETS_BIT  victim way chosen by cache
victim_dirty_i  in  1  victim line dirty
victim_tag_i  in  TAG_BIT  victim tag
victim_line_i  in  SRAM_DATA_BIT  victim line data
miss_ack_o  out  1  one-cycle completion pulse
busy_o  out  1  high in every state except IDLE
fill_valid_o  out  1  one-cycle line-fill strobe
fill_way_o  out  SETS_BIT  way to fill
fill_index_o  out  INDEX_BIT  set to fill
fill_tag_o  out  TAG_BIT  tag to install
fill_line_o  out  SRAM_DATA_BIT  fetched line
SRAM_ena_o  out  1  SRAM enable
SRAM_wea_o  out  1  SRAM write enable
SRAM_addr_o  out  SRAM_ADDR_BIT  line address {tag,index}
SRAM_data_o  out  SRAM_DATA_BIT  write-back data
SRAM_data_i  in  SRAM_DATA_BIT  SRAM read data
miss_cnt_o  out  CNT_BIT  accepted-miss count, saturating
wb_cnt_o  out  CNT_BIT  write-back count, saturating

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - All outputs and latched request fields go to 0, including both counters.
  - A reset mid-operation abandons the transfer; no ack is issued.
- States: IDLE, WB, RD, WAIT, FILL.
- IDLE:
  - If miss_req_i=1, latch tag/index/way/victim_dirty/victim_tag/victim_line and increment miss_cnt.
  - Go to WB if victim_dirty_i=1, else go to RD.
- WB (1 cycle):
  - Drive SRAM_ena_o=1, SRAM_wea_o=1, SRAM_addr_o={victim_tag,index}, SRAM_data_o=latched victim line.
  - Increment wb_cnt; go to RD.
- RD (1 cycle):
  - Drive SRAM_ena_o=1, SRAM_wea_o=0, SRAM_addr_o={miss_tag,index}.
  - Load the latency counter with SRAM_RD_LAT; go to WAIT.
- WAIT (SRAM_RD_LAT cycles):
  - Decrement the counter each cycle.
  - On the cycle the counter equals 1, capture SRAM_data_i into the fill register and go to FILL.
  - SRAM_ena_o is 0 throughout.
- FILL (1 cycle):
  - Assert fill_valid_o=1 and miss_ack_o=1 together.
  - fill_* fields carry latched values; return to IDLE.
- Latency from the first request cycle to ack: clean = SRAM_RD_LAT+2 cycles; dirty = SRAM_RD_LAT+3.
- SRAM_ena_o, SRAM_wea_o, SRAM_addr_o and SRAM_data_o are registered. SRAM_ena_o is 0 in IDLE, WAIT and FILL.
- Handshake:
  - The requester drops miss_req_i in the cycle after it samples the ack.
  - Request inputs are ignored outside IDLE; changes or deassertion mid-operation do not abort it.
  - A new request is accepted at the earliest in the cycle after FILL.
- fill_line_o holds its last captured value until the next capture.
- Counters saturate at all-ones and do not wrap.

Decomposition:
- Package cache_pkg holds:
  - the state enum;
  - SRAM_ADDR_BIT consistency check;
  - function line_addr(tag,index) returning {tag,index}.
- Sub-module sat_counter (parameter CNT_BIT; inc_i, cnt_o), instanced twice for miss_cnt and wb_cnt.

Test Plan:
- Clean miss, tag 0x10, index 0, way 2, SRAM_RD_LAT=1, SRAM line 0x40 preloaded with 0x0123456789abcdef at bit 176:
  - RD issues addr 0x40, wea=0.
  - Ack arrives 3 cycles after request.
  - fill_line_o[176+:64]=0x0123456789abcdef, fill_way_o=2; miss_cnt=1, wb_cnt=0.
- Dirty miss, victim tag 0x11, index 0:
  - WB writes line 0x44 with wea=1.
  - Next cycle RD reads 0x40; ack at cycle 4; wb_cnt=1.
  - A second read of 0x44 returns the victim data.
- SRAM_RD_LAT=4 build, clean miss: ack at cycle 6; no SRAM_ena_o during WAIT.
- Reset pulsed during WAIT:
  - All outputs go to 0 immediately; no ack.
  - The next request completes normally.
- miss_req_i dropped during RD: operation still completes with a single ack.
- Back-to-back requests with the request re-raised right after ack: second accepted only in the IDLE cycle after FILL.
- CNT_BIT=2 build with 5 misses: miss_cnt_o saturates at 3.
